// File: rtl/turbo_pkg.sv
// Shared parameters, state encoding and QPP helper for the turbo encoder slice.
package turbo_pkg;

  localparam int K  = 16;
  localparam int M  = 3;
  localparam int F1 = 3;
  localparam int F2 = 4;
  localparam int OW = 3 * K + 4 * M;
  localparam int IW = $clog2(K);
  localparam int TW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit i is the coefficient of D^i.
  localparam logic [M:0] FB_POLY = 4'b1101;  // 1 + D^2 + D^3
  localparam logic [M:0] FF_POLY = 4'b1011;  // 1 + D + D^3

  localparam logic [IW-1:0] G_INIT = IW'((F1 + F2) % K);
  localparam logic [IW-1:0] G_STEP = IW'((2 * F2) % K);

  function automatic logic [IW-1:0] qpp(input int unsigned idx);
    int unsigned v;
    v = (F1 * idx + F2 * idx * idx) % K;
    return v[IW-1:0];
  endfunction

endpackage

// File: rtl/turbo_encoder_rsc.sv
// Memory-3 recursive systematic convolutional encoder with trellis termination.
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tail,
  input  logic i_u,
  output logic o_x,
  output logic o_z
);

  // s_q[0] is the newest stage s1, s_q[M-1] the oldest.
  logic [M-1:0] s_q, s_d;
  logic         fb;
  logic         x;
  logic         a;

  always_comb begin
    fb = ^(s_q & FB_POLY[M:1]);
    // Feeding the feedback back in as input drives the register toward zero.
    x  = i_tail ? fb : i_u;
    a  = x ^ fb;
    o_x = x;
    o_z = (a & FF_POLY[0]) ^ (^(s_q & FF_POLY[M:1]));
    if (i_clr) begin
      s_d = '0;
    end else if (i_en) begin
      s_d = {s_q[M-2:0], a};
    end else begin
      s_d = s_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/turbo_encoder.sv
// Turbo encoder top: block register, FSM, QPP address generator and codeword packing.
module turbo_encoder
  import turbo_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [K-1:0]  i_data,
  output logic          o_ready,
  output logic          o_done,
  output logic [OW-1:0] o_data
);

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] pi_q, pi_d;
  logic [IW-1:0] g_q, g_d;
  logic [TW-1:0] t_q, t_d;
  logic [K-1:0]  blk_q, blk_d;
  logic [OW-1:0] data_q, data_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          enc_clr, enc_en, enc_tail;
  logic          x1, z1, x2, z2;

  rsc_encoder u_enc1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (enc_clr),
    .i_en   (enc_en),
    .i_tail (enc_tail),
    .i_u    (blk_q[i_q]),
    .o_x    (x1),
    .o_z    (z1)
  );

  rsc_encoder u_enc2 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (enc_clr),
    .i_en   (enc_en),
    .i_tail (enc_tail),
    .i_u    (blk_q[pi_q]),
    .o_x    (x2),
    .o_z    (z2)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    pi_d     = pi_q;
    g_d      = g_q;
    t_d      = t_q;
    blk_d    = blk_q;
    data_d   = data_q;
    enc_clr  = 1'b0;
    enc_en   = 1'b0;
    enc_tail = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          blk_d   = i_data;
          enc_clr = 1'b1;
          i_d     = '0;
          pi_d    = '0;
          g_d     = G_INIT;
          t_d     = '0;
          data_d  = '0;
          state_d = ENC;
        end else begin
          state_d = IDLE;
        end
      end
      ENC: begin
        enc_en = 1'b1;
        data_d[3*int'(i_q) +: 3] = {z2, z1, x1};
        i_d  = i_q + IW'(1);
        // QPP by second differences: pi += g, g += 2*F2, all mod K.
        pi_d = pi_q + g_q;
        g_d  = g_q + G_STEP;
        if (i_q == IW'(K - 1)) begin
          state_d = TAIL;
        end else begin
          state_d = ENC;
        end
      end
      TAIL: begin
        enc_en   = 1'b1;
        enc_tail = 1'b1;
        data_d[3*K + 2*int'(t_q) +: 2]       = {z1, x1};
        data_d[3*K + 2*M + 2*int'(t_q) +: 2] = {z2, x2};
        t_d = t_q + TW'(1);
        if (t_q == TW'(M - 1)) begin
          state_d = DONE;
        end else begin
          state_d = TAIL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      pi_q    <= '0;
      g_q     <= '0;
      t_q     <= '0;
      blk_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
      t_q     <= t_d;
      blk_q   <= blk_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_data  = data_q;

endmodule
